// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops TX FIFO words and serialises start/data/[parity]/stop bits,
// timing each bit from an OVERSAMPLE x baud tick. Parity support: define UART_TX_SEQUENCER_PARITY_EN.
module uart_tx_sequencer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic              enable,
  input  logic [1:0]        word_len,
  input  logic              stop2,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              fifo_empty,
  input  logic [FIFO_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              uart_tx,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        state_out
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [1:0]    wl_q;
  logic          stop2_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          load;
  logic          bit_end;
  logic [2:0]    last_bit;
  logic          unused_ok;

`ifdef UART_TX_SEQUENCER_PARITY_EN
  logic          pen_q;
  logic          par_q;
  logic [7:0]    data_mask;
  logic          par_calc;

  always_comb begin
    data_mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(word_len) + 32'd5) data_mask[i] = 1'b1;
    end
  end

  assign par_calc = (^(fifo_data[7:0] & data_mask)) ^ parity_odd;
`endif

  // Loads only on a tick so every bit lasts exactly OVERSAMPLE ticks.
  assign load      = (state_q == IDLE) && baud_tick && enable && !fifo_empty;
  assign bit_end   = baud_tick && (tick_q == TW'(OVERSAMPLE - 1));
  assign last_bit  = {1'b0, wl_q} + 3'd4;
  assign unused_ok = ^{parity_en, parity_odd, fifo_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wl_q    <= '0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_SEQUENCER_PARITY_EN
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && baud_tick) tick_q <= bit_end ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q <= START;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            shift_q <= fifo_data[7:0];
            tick_q  <= '0;
            bit_q   <= '0;
            wl_q    <= word_len;
            stop2_q <= stop2;
`ifdef UART_TX_SEQUENCER_PARITY_EN
            pen_q   <= parity_en;
            par_q   <= par_calc;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_q == last_bit) begin
`ifdef UART_TX_SEQUENCER_PARITY_EN
              if (pen_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
                bit_q   <= '0;
              end
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
              bit_q   <= '0;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
`ifdef UART_TX_SEQUENCER_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end
        end
`endif
        STOP: begin
          // bit_q marks the first of two stop bits already sent.
          if (bit_end) begin
            if (stop2_q && bit_q == 3'd0) begin
              bit_q <= 3'd1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_read  = load;
  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: stimulus queues expected line patterns,
// a monitor decodes each frame cycle by cycle off the serial line.
`timescale 1ns/1ps
module tb_uart_tx_sequencer;

  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLK  = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       enable;
  logic [1:0] word_len;
  logic       stop2;
  logic       parity_en;
  logic       parity_odd;
  logic       fifo_empty;
  logic [8:0] fifo_data;
  logic       fifo_read;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] state_out;

  uart_tx_sequencer #(.OVERSAMPLE(OS), .FIFO_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .enable     (enable),
    .word_len   (word_len),
    .stop2      (stop2),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  // pat bit i is the line level during serial bit i (bit 0 = start).
  typedef struct {
    logic [15:0] pat;
    int unsigned nd;
    int unsigned npar;
    int unsigned nstop;
    int          gap_max;
    bit          abort;
  } exp_t;

  exp_t        sb[$];
  logic [8:0]  fq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned pops = 0;
  int unsigned last_end = 0;
  bit          mon_busy = 1'b0;
  int unsigned div = 0;
  bit          pop_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic check_le(input string name, input int unsigned got, input int unsigned max);
    checks++;
    if (got > max) begin
      errors++;
      $display("FAIL %s: got %0d want <= %0d", name, got, max);
    end
  endtask

  task automatic push_exp(input logic [15:0] pat, input int unsigned nd, input int unsigned npar,
                          input int unsigned nstop, input int gap_max, input bit abort);
    exp_t e;
    e.pat = pat; e.nd = nd; e.npar = npar; e.nstop = nstop; e.gap_max = gap_max; e.abort = abort;
    sb.push_back(e);
  endtask

  // FIFO model and baud tick: pops are sampled just before the edge, applied at the next negedge.
  initial begin : driver
    baud_tick  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        if (fq.size() != 0) void'(fq.pop_front());
        pops++;
      end
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? 9'h000 : fq[0];
      baud_tick  = (div == 0);
      div        = (div + 1) % TICK_DIV;
      #4;
      pop_pending = fifo_read;
      if (fifo_read) check("read_nonempty", 32'(fifo_empty), 32'd0);
    end
  end

  task automatic check_frame(input exp_t e);
    int unsigned nb, nclk, b, es;
    int unsigned bad_line = 0;
    int unsigned bad_ctl = 0;
    bit aborted = 1'b0;
    nb   = 1 + e.nd + e.npar + e.nstop;
    nclk = nb * BIT_CLK;
    if (e.gap_max >= 0) check_le("start_gap", cyc - last_end, e.gap_max);
    for (int unsigned i = 0; i < nclk; i++) begin
      if (i != 0) @(negedge clk);
      if (reset !== 1'b1) begin
        aborted = 1'b1;
        break;
      end
      b = i / BIT_CLK;
      if (b == 0) es = 1;
      else if (b <= e.nd) es = 2;
      else if (e.npar != 0 && b == e.nd + 1) es = 3;
      else es = 4;
      if (uart_tx !== e.pat[b]) bad_line++;
      if (state_out !== 3'(es) || busy !== 1'b1 || frame_done !== 1'b0) bad_ctl++;
    end
    check("frame_line_errs", bad_line, 0);
    check("frame_ctl_errs", bad_ctl, 0);
    if (!aborted) begin
      @(negedge clk);
      check("frame_end {done,busy,tx,state}", 32'({frame_done, busy, uart_tx, state_out}), 32'b101000);
      last_end = cyc;
    end
    if (e.abort) check("frame_aborted", 32'(aborted), 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && prev === 1'b1 && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit at cycle %0d want idle line", cyc);
        end else begin
          e = sb.pop_front();
          check_frame(e);
        end
        mon_busy = 1'b0;
      end
      prev = uart_tx;
    end
  end

  task automatic wait_idle(input string tag);
    int unsigned n;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !mon_busy && !busy) break;
    end
    check({"idle_", tag}, 32'(n < 4000), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int unsigned n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (mon_busy) break;
    end
    check({"start_", tag}, 32'(n < 200), 32'd1);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got no finish want finish before 3ms");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int unsigned n;
    reset = 1'b0; enable = 1'b0; word_len = 2'b11; stop2 = 1'b0;
    parity_en = 1'b0; parity_odd = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1, 0x55
    enable = 1'b1; word_len = 2'b11; stop2 = 1'b0;
    push_exp(16'h02AA, 8, 0, 1, -1, 1'b0);
    fq.push_back(9'h055);
    wait_idle("8n1");
    check("pops_8n1", pops, 1);

    // 5 data bits, 2 stop bits, 0x1F3
    word_len = 2'b00; stop2 = 1'b1;
    push_exp(16'h00E6, 5, 0, 2, -1, 1'b0);
    fq.push_back(9'h1F3);
    wait_idle("5n2");
    check("pops_5n2", pops, 2);

    // Parity on 0x07, even then odd
    word_len = 2'b11; stop2 = 1'b0; parity_en = 1'b1; parity_odd = 1'b0;
`ifdef UART_TX_SEQUENCER_PARITY_EN
    push_exp(16'h060E, 8, 1, 1, -1, 1'b0);
`else
    push_exp(16'h020E, 8, 0, 1, -1, 1'b0);
`endif
    fq.push_back(9'h007);
    wait_idle("par_even");
    parity_odd = 1'b1;
`ifdef UART_TX_SEQUENCER_PARITY_EN
    push_exp(16'h040E, 8, 1, 1, -1, 1'b0);
`else
    push_exp(16'h020E, 8, 0, 1, -1, 1'b0);
`endif
    fq.push_back(9'h007);
    wait_idle("par_odd");
    check("pops_par", pops, 4);
    parity_en = 1'b0; parity_odd = 1'b0;

    // Back-to-back 0xA5, 0x3C
    push_exp(16'h034A, 8, 0, 1, -1, 1'b0);
    push_exp(16'h0278, 8, 0, 1, TICK_DIV, 1'b0);
    fq.push_back(9'h0A5);
    fq.push_back(9'h03C);
    wait_idle("b2b");
    repeat (100) @(negedge clk);
    check("pops_b2b", pops, 6);

    // Enable dropped during data bit 3; queued word held until re-enabled
    push_exp(16'h032C, 8, 0, 1, -1, 1'b0);
    fq.push_back(9'h096);
    wait_start("en_drop");
    repeat (4 * BIT_CLK + 20) @(negedge clk);
    enable = 1'b0;
    fq.push_back(9'h00F);
    wait_idle("en_drop");
    repeat (60) @(negedge clk);
    check("pops_disabled", pops, 7);
    check("busy_disabled", 32'(busy), 32'd0);
    push_exp(16'h021E, 8, 0, 1, -1, 1'b0);
    enable = 1'b1;
    #1;
    for (n = 0; n < 8; n++) begin
      if (fifo_read) break;
      @(negedge clk); #4;
    end
    check_le("read_after_enable", n, TICK_DIV - 1);
    wait_idle("reenable");
    check("pops_reenable", pops, 8);

    // Reset mid-frame during bit 4, then 0x81
    push_exp(16'h0288, 8, 0, 1, -1, 1'b1);
    fq.push_back(9'h044);
    wait_start("rst_mid");
    repeat (4 * BIT_CLK + 30) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_uart_tx", 32'(uart_tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(state_out), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_exp(16'h0302, 8, 0, 1, -1, 1'b0);
    fq.push_back(9'h081);
    wait_idle("after_rst");
    check("pops_final", pops, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
